// File: rtl/arbitro_pkg.sv
// Shared types and constants for the round-robin output arbiter.
package arbitro_pkg;

  localparam int NUM_LANES = 4;
  localparam logic [2:0] IDX_TOTAL = 3'd4;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/arbitro_salida_rr_if.sv
// Lane FIFO / egress / counter-readout bundle seen by the arbiter (slave) and its driver (master).
interface arbitro_salida_rr_if
  import arbitro_pkg::*;
#(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5
);
  logic                    init;
  logic [TAMANO_DATOS-1:0] fifo_data0;
  logic [TAMANO_DATOS-1:0] fifo_data1;
  logic [TAMANO_DATOS-1:0] fifo_data2;
  logic [TAMANO_DATOS-1:0] fifo_data3;
  logic [NUM_LANES-1:0]    fifo_empty;
  logic                    dest_almost_full;
  logic [NUM_LANES-1:0]    pop;
  logic [TAMANO_DATOS-1:0] data_out;
  logic                    valid_out;
  logic                    req;
  logic [2:0]              idx;
  logic [CNT_W-1:0]        cnt_data;
  logic                    cnt_valid;

  modport slave (
    input  init, fifo_data0, fifo_data1, fifo_data2, fifo_data3, fifo_empty,
           dest_almost_full, req, idx,
    output pop, data_out, valid_out, cnt_data, cnt_valid
  );

  modport master (
    output init, fifo_data0, fifo_data1, fifo_data2, fifo_data3, fifo_empty,
           dest_almost_full, req, idx,
    input  pop, data_out, valid_out, cnt_data, cnt_valid
  );

endinterface

// File: rtl/rr_sel.sv
// Combinational round-robin picker: first eligible lane scanning upward from rr_ptr.
module rr_sel
  import arbitro_pkg::*;
(
  input  logic [NUM_LANES-1:0] elig,
  input  logic [1:0]           rr_ptr,
  output logic [NUM_LANES-1:0] grant,
  output logic [1:0]           sel,
  output logic                 any
);

  logic [1:0] cand;

  // Scan from the farthest offset down so the closest eligible lane wins.
  always_comb begin
    grant = '0;
    sel   = rr_ptr;
    cand  = '0;
    any   = |elig;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (elig[cand]) sel = cand;
    end
    if (any) grant[sel] = 1'b1;
  end

endmodule

// File: rtl/arbitro_salida_rr.sv
// Round-robin merge of four lane FIFOs into one registered stream, with per-lane word counters.
module arbitro_salida_rr
  import arbitro_pkg::*;
#(
  parameter int TAMANO_DATOS = 12,
  parameter int CNT_W        = 5
) (
  input  logic clk,
  input  logic reset,
  arbitro_salida_rr_if.slave bus
);

  state_t                  state_q;
  state_t                  state_d;
  logic [1:0]              rr_ptr;
  logic [NUM_LANES-1:0]    grant;
  logic [1:0]              sel;
  logic                    any;
  logic                    pop_en;
  logic [NUM_LANES-1:0]    pop_c;

  logic                    vld_p0;
  logic [1:0]              sel_p0;
  logic                    vld_p1;
  logic [TAMANO_DATOS-1:0] data_p1;
  logic [TAMANO_DATOS-1:0] lane_word;

  logic [CNT_W-1:0]        lane_cnt [NUM_LANES];
  logic [CNT_W-1:0]        total_cnt;
  logic [CNT_W-1:0]        rd_word;
  logic [CNT_W-1:0]        cnt_data_q;
  logic                    cnt_valid_q;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  rr_sel u_rr_sel (
    .elig   (~bus.fifo_empty),
    .rr_ptr (rr_ptr),
    .grant  (grant),
    .sel    (sel),
    .any    (any)
  );

  // Granting depends on eligibility and gating, not on IDLE vs ACTIVE.
  always_comb begin
    state_d = state_q;
    pop_en  = (state_q != INIT) && !bus.init && !bus.dest_almost_full && any;
    pop_c   = '0;
    if (pop_en) pop_c = grant;
    case (state_q)
      INIT:    state_d = IDLE;
      IDLE:    if (any && !bus.dest_almost_full) state_d = ACTIVE;
      ACTIVE:  if (!pop_en) state_d = IDLE;
      default: state_d = INIT;
    endcase
    if (bus.init) state_d = INIT;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= INIT;
      rr_ptr  <= '0;
    end else begin
      state_q <= state_d;
      if (bus.init)    rr_ptr <= '0;
      else if (pop_en) rr_ptr <= sel + 2'd1;
    end
  end

  always_comb begin
    lane_word = '0;
    case (sel_p0)
      2'd0:    lane_word = bus.fifo_data0;
      2'd1:    lane_word = bus.fifo_data1;
      2'd2:    lane_word = bus.fifo_data2;
      default: lane_word = bus.fifo_data3;
    endcase
  end

  // p0: pop issued, FIFO presents the word next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      sel_p0 <= '0;
    end else begin
      vld_p0 <= pop_en;
      if (pop_en) sel_p0 <= sel;
    end
  end

  // p1: capture the popped word into the merged output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) data_p1 <= lane_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
      total_cnt <= '0;
    end else if (bus.init) begin
      for (int i = 0; i < NUM_LANES; i++) lane_cnt[i] <= '0;
      total_cnt <= '0;
    end else if (vld_p0) begin
      lane_cnt[sel_p0] <= cnt_inc(lane_cnt[sel_p0]);
      total_cnt        <= cnt_inc(total_cnt);
    end
  end

  always_comb begin
    rd_word = '0;
    if (bus.idx == IDX_TOTAL)     rd_word = total_cnt;
    else if (bus.idx < IDX_TOTAL) rd_word = lane_cnt[bus.idx[1:0]];
  end

  // Readout samples pre-edge counter values, so a coinciding increment is not seen.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_data_q  <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      cnt_valid_q <= bus.req;
      if (bus.req) cnt_data_q <= rd_word;
    end
  end

  assign bus.pop       = pop_c;
  assign bus.data_out  = data_p1;
  assign bus.valid_out = vld_p1;
  assign bus.cnt_data  = cnt_data_q;
  assign bus.cnt_valid = cnt_valid_q;

endmodule

// File: tb/tb_arbitro_salida_rr.sv
// Scoreboard bench for arbitro_salida_rr: lane FIFO model, round-robin reference and counter model.
module tb_arbitro_salida_rr;
  import arbitro_pkg::*;

  localparam int DW = 12;
  localparam int CW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_salida_rr_if #(.TAMANO_DATOS(DW), .CNT_W(CW)) bus ();
  arbitro_salida_rr #(.TAMANO_DATOS(DW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic [DW-1:0] w; int cyc; } dexp_t;
  typedef struct { logic [CW-1:0] v; int cyc; } cexp_t;

  logic [DW-1:0] lane_q [4][$];
  logic [DW-1:0] fd [4] = '{default: '0};
  logic [3:0]    emp_r = 4'hF;
  logic [3:0]    pop_s = 4'h0;

  assign bus.fifo_data0 = fd[0];
  assign bus.fifo_data1 = fd[1];
  assign bus.fifo_data2 = fd[2];
  assign bus.fifo_data3 = fd[3];
  assign bus.fifo_empty = emp_r;

  dexp_t exp_q[$];
  cexp_t cnt_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    in_init;
  int    ptr_m;
  bit    pend;
  int    pend_lane;
  logic [CW-1:0] cnt_m [4];
  logic [CW-1:0] tot_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [CW-1:0] read_m(input logic [2:0] i);
    if (i < 3'd4)  return cnt_m[i[1:0]];
    if (i == 3'd4) return tot_m;
    return '0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cnt_q.delete();
    pend    = 1'b0;
    ptr_m   = 0;
    in_init = 1'b1;
    tot_m   = '0;
    for (int i = 0; i < 4; i++) cnt_m[i] = '0;
  endtask

  // Lane FIFOs: registered read data, empty flag updated on the pop edge.
  always @(posedge clk) begin
    logic [3:0] nxt;
    for (int i = 0; i < 4; i++) begin
      if (pop_s[i] && lane_q[i].size() > 0) fd[i] <= lane_q[i].pop_front();
      nxt[i] = (lane_q[i].size() == 0);
    end
    emp_r <= nxt;
  end

  // Monitor and reference model, evaluated mid-cycle for the upcoming edge.
  always @(negedge clk) begin
    logic [3:0] e_pop;
    int gl;
    dexp_t de;
    cexp_t ce;
    cyc++;
    pop_s = bus.pop;
    if (bus.valid_out) begin
      if (exp_q.size() == 0) chk("valid_unexpected", 32'(bus.valid_out), 32'h0);
      else begin
        de = exp_q.pop_front();
        chk("data_out", 32'(bus.data_out), 32'(de.w));
        chk("data_latency", 32'(cyc), 32'(de.cyc));
      end
    end
    if (bus.cnt_valid) begin
      if (cnt_q.size() == 0) chk("cnt_valid_unexpected", 32'(bus.cnt_valid), 32'h0);
      else begin
        ce = cnt_q.pop_front();
        chk("cnt_data", 32'(bus.cnt_data), 32'(ce.v));
        chk("cnt_latency", 32'(cyc), 32'(ce.cyc));
      end
    end
    e_pop = 4'h0;
    gl = -1;
    if (reset && !in_init && !bus.init && !bus.dest_almost_full)
      for (int k = 0; k < 4; k++)
        if (gl < 0 && !bus.fifo_empty[(ptr_m + k) % 4]) gl = (ptr_m + k) % 4;
    if (gl >= 0) e_pop[gl] = 1'b1;
    chk("pop", 32'(bus.pop), 32'(e_pop));
    if (reset) begin
      if (bus.req) cnt_q.push_back('{read_m(bus.idx), cyc + 1});
      if (bus.init) begin
        for (int i = 0; i < 4; i++) cnt_m[i] = '0;
        tot_m = '0;
      end else if (pend) begin
        cnt_m[pend_lane] = cnt_m[pend_lane] + CW'(1);
        tot_m = tot_m + CW'(1);
      end
      pend = (gl >= 0);
      pend_lane = gl;
      if (gl >= 0) begin
        if (lane_q[gl].size() > 0) exp_q.push_back('{lane_q[gl][0], cyc + 2});
        ptr_m = (gl + 1) % 4;
      end
      if (bus.init) ptr_m = 0;
      in_init = bus.init;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      busy = (exp_q.size() != 0) || (cnt_q.size() != 0);
      for (int i = 0; i < 4; i++) if (lane_q[i].size() != 0) busy = 1'b1;
      if (busy) begin
        tick(1);
        n++;
      end
    end
    chk("drain_done", 32'(!busy), 32'h1);
  endtask

  task automatic init_pulse();
    bus.init = 1'b1;
    tick(1);
    bus.init = 1'b0;
    tick(1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    bus.init = 1'b1;
    bus.dest_almost_full = 1'b0;
    bus.req = 1'b0;
    bus.idx = 3'd0;
    model_reset();
    lane_q[0].push_back(12'h4A4);
    lane_q[1].push_back(12'h415);
    lane_q[2].push_back(12'h4A5);
    lane_q[3].push_back(12'hC8D);
    tick(3);
    reset = 1'b1;
    tick(2);
    chk("rst_pop", 32'(bus.pop), 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_cnt_valid", 32'(bus.cnt_valid), 32'h0);
    chk("rst_cnt_data", 32'(bus.cnt_data), 32'h0);

    bus.init = 1'b0;
    tick(1);
    chk("seq_pop0", 32'(bus.pop), 32'h1);
    tick(1);
    chk("seq_pop1", 32'(bus.pop), 32'h2);
    tick(1);
    chk("seq_pop2", 32'(bus.pop), 32'h4);
    tick(1);
    chk("seq_pop3", 32'(bus.pop), 32'h8);
    drain(50);

    init_pulse();
    for (int i = 0; i < 3; i++) lane_q[2].push_back(DW'(12'h300 + i));
    drain(50);
    bus.req = 1'b1;
    bus.idx = 3'd2;
    tick(1);
    bus.idx = 3'd4;
    tick(1);
    bus.idx = 3'd0;
    tick(1);
    bus.req = 1'b0;
    drain(20);

    for (int r = 0; r < 2; r++)
      for (int l = 0; l < 4; l++) lane_q[l].push_back(DW'($urandom));
    bus.dest_almost_full = 1'b1;
    tick(4);
    chk("daf_block", 32'(bus.pop), 32'h0);
    bus.dest_almost_full = 1'b0;
    drain(60);

    init_pulse();
    for (int i = 0; i < 31; i++) lane_q[1].push_back(DW'($urandom));
    drain(100);
    bus.req = 1'b1;
    bus.idx = 3'd1;
    tick(1);
    lane_q[1].push_back(DW'($urandom));
    tick(6);
    bus.req = 1'b0;
    drain(20);

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int l;
        l = int'($urandom_range(0, 3));
        if (lane_q[l].size() < 6) lane_q[l].push_back(DW'($urandom));
      end
      bus.dest_almost_full = ($urandom_range(0, 5) == 0);
      bus.req  = ($urandom_range(0, 2) == 0);
      bus.idx  = 3'($urandom_range(0, 7));
      bus.init = ($urandom_range(0, 49) == 0);
      tick(1);
    end
    bus.dest_almost_full = 1'b0;
    bus.req  = 1'b0;
    bus.init = 1'b0;
    drain(200);

    for (int i = 0; i < 3; i++) begin
      lane_q[0].push_back(DW'($urandom));
      lane_q[1].push_back(DW'($urandom));
    end
    tick(3);
    reset = 1'b0;
    bus.init = 1'b1;
    model_reset();
    #1;
    chk("midrst_valid", 32'(bus.valid_out), 32'h0);
    chk("midrst_data", 32'(bus.data_out), 32'h0);
    chk("midrst_pop", 32'(bus.pop), 32'h0);
    tick(2);
    reset = 1'b1;
    bus.req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.idx = 3'(i);
      tick(1);
    end
    bus.req = 1'b0;
    bus.init = 1'b0;
    drain(60);
    tick(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
